// File: rtl/vga_sync_gen.sv
// VGA 640x480@60 timing generator running on clk100 with an internal 1-in-CLK_DIV pixel enable.
// Latency: all outputs registered from next-state counters; x/y/syncs/video_on describe the same pixel.
// No backpressure: free-running timing source; optional VGA_FRAME_COUNT_EN adds a 16-bit frame counter.
module vga_sync_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk100,
  input  logic        rst_n,
  output logic        pix_en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div;
  logic [DW-1:0] div_nxt;
  logic [9:0]    h_cnt;
  logic [9:0]    v_cnt;
  logic [9:0]    h_nxt;
  logic [9:0]    v_nxt;
  logic          step;
  logic          h_wrap;
  logic          f_wrap;
  logic          hs_win;
  logic          vs_win;
  logic          vid_nxt;

  // Next-state divider and counters; the counters move on the edge that closes a pix_en cycle.
  always_comb begin
    step    = (div == DIV_LAST);
    div_nxt = step ? '0 : div + 1'b1;
    h_wrap  = step && (h_cnt == H_LAST);
    f_wrap  = h_wrap && (v_cnt == V_LAST);
    h_nxt   = h_cnt;
    if (step) begin
      h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
    end
    v_nxt = v_cnt;
    if (h_wrap) begin
      v_nxt = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
    end
    hs_win  = (h_nxt >= HS_BEG) && (h_nxt < HS_END);
    vs_win  = (v_nxt >= VS_BEG) && (v_nxt < VS_END);
    vid_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
  end

  // State and registered outputs, all derived from the same next-state values so nothing skews.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      div         <= '0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      pix_en      <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      video_on    <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div         <= div_nxt;
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      pix_en      <= (div_nxt == DIV_LAST);
      hsync       <= hs_win ? SYNC_POL : ~SYNC_POL;
      vsync       <= vs_win ? SYNC_POL : ~SYNC_POL;
      video_on    <= vid_nxt;
      line_start  <= h_wrap;
      frame_start <= f_wrap;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Completed-frame counter, bumped on the same edge that raises frame_start; wraps naturally.
  always_ff @(posedge clk100) begin
    if (!rst_n) begin
      frame_count <= 16'd0;
    end else if (f_wrap) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

  assign x = h_cnt;
  assign y = v_cnt;

endmodule

// File: tb/tb_vga_sync_gen.sv
`timescale 1ns/1ps
module tb_vga_sync_gen;

  logic clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  logic rst_n;

  // Instance A: default 640x480 timing.  Instance B: tiny timing so whole frames fit the run.
  logic       a_pix_en, a_hsync, a_vsync, a_video_on, a_line_start, a_frame_start;
  logic [9:0] a_x, a_y;
  logic       b_pix_en, b_hsync, b_vsync, b_video_on, b_line_start, b_frame_start;
  logic [9:0] b_x, b_y;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] a_frame_count, b_frame_count;
`endif

  vga_sync_gen u_a (
    .clk100(clk100), .rst_n(rst_n), .pix_en(a_pix_en), .hsync(a_hsync), .vsync(a_vsync),
    .video_on(a_video_on), .x(a_x), .y(a_y), .line_start(a_line_start), .frame_start(a_frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(a_frame_count)
`endif
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2), .SYNC_POL(1'b1)
  ) u_b (
    .clk100(clk100), .rst_n(rst_n), .pix_en(b_pix_en), .hsync(b_hsync), .vsync(b_vsync),
    .video_on(b_video_on), .x(b_x), .y(b_y), .line_start(b_line_start), .frame_start(b_frame_start)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(b_frame_count)
`endif
  );

  typedef struct packed {
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        line_start;
    logic        frame_start;
    logic [15:0] fc;
  } obs_t;

  int checks   = 0;
  int failures = 0;
  obs_t qa[$];
  obs_t qb[$];

  // Reference: everything follows from k = clock edges since the last reset edge.
  // Pixel index p = k/d; position and frame number fall out of division by line/frame length.
  function automatic obs_t ref_obs(longint k, int d, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb, bit pol);
    obs_t   o;
    int     ht, vt, xx, yy;
    longint p;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p  = k / d;
    xx = int'(p % ht);
    yy = int'((p / ht) % vt);
    o.pix_en      = ((k % d) == d - 1);
    o.x           = 10'(xx);
    o.y           = 10'(yy);
    o.hsync       = (xx >= ha + hf && xx < ha + hf + hs) ? pol : ~pol;
    o.vsync       = (yy >= va + vf && yy < va + vf + vs) ? pol : ~pol;
    o.video_on    = (k > 0) && (xx < ha) && (yy < va);
    o.line_start  = (k > 0) && ((k % d) == 0) && (xx == 0);
    o.frame_start = o.line_start && (yy == 0);
`ifdef VGA_FRAME_COUNT_EN
    o.fc          = 16'(p / (ht * vt));
`else
    o.fc          = 16'd0;
`endif
    return o;
  endfunction

  task automatic chk(input string name, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Reference model: pushes one expected observation per DUT per clock edge.
  initial begin
    longint k;
    bit     synced;
    k = 0;
    synced = 1'b0;
    forever begin
      @(posedge clk100);
      if (!rst_n) begin
        synced = 1'b1;
        k = 0;
      end else if (synced) begin
        k++;
      end
      if (synced) begin
        qa.push_back(ref_obs(k, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0));
        qb.push_back(ref_obs(k, 3, 10, 2, 3, 2, 6, 1, 2, 2, 1'b1));
      end
    end
  end

  // Monitor: pops and compares on the falling edge, away from the active edge.
  initial begin
    obs_t e, g;
    longint cyc;
    cyc = 0;
    forever begin
      @(negedge clk100);
      cyc++;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        g.pix_en = a_pix_en; g.hsync = a_hsync; g.vsync = a_vsync; g.video_on = a_video_on;
        g.x = a_x; g.y = a_y; g.line_start = a_line_start; g.frame_start = a_frame_start;
`ifdef VGA_FRAME_COUNT_EN
        g.fc = a_frame_count;
`else
        g.fc = 16'd0;
`endif
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL sb_a cyc=%0d got=%h expected=%h", cyc, g, e);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        g.pix_en = b_pix_en; g.hsync = b_hsync; g.vsync = b_vsync; g.video_on = b_video_on;
        g.x = b_x; g.y = b_y; g.line_start = b_line_start; g.frame_start = b_frame_start;
`ifdef VGA_FRAME_COUNT_EN
        g.fc = b_frame_count;
`else
        g.fc = 16'd0;
`endif
        checks++;
        if (g !== e) begin
          failures++;
          $display("FAIL sb_b cyc=%0d got=%h expected=%h", cyc, g, e);
        end
      end
    end
  end

  // Stimulus plus directed timing measurements.
  initial begin
    int pe_cyc[$];
    int pe_x[$];
    int ls_cyc[$];
    int fs_cyc[$];
    int hs_start, hs_x, hs_len, vs_start, vs_y, vs_len;
    logic a_hs_prev, b_vs_prev;

    rst_n = 1'b0;
    repeat (10) @(negedge clk100);
    chk("rst_pix_en", a_pix_en, 0);
    chk("rst_hsync", a_hsync, 1);
    chk("rst_vsync", a_vsync, 1);
    chk("rst_video_on", a_video_on, 0);
    chk("rst_x", a_x, 0);
    chk("rst_y", a_y, 0);
    chk("rst_strobes", {a_line_start, a_frame_start}, 0);
    chk("rst_b_hsync_pol", b_hsync, 0);

    // Cycle 1 is the cycle in which rst_n is first seen high.
    rst_n = 1'b1;
    hs_start = -1; hs_x = -1; hs_len = -1;
    vs_start = -1; vs_y = -1; vs_len = -1;
    a_hs_prev = a_hsync;
    b_vs_prev = b_vsync;
    for (int c = 2; c <= 7001; c++) begin
      @(negedge clk100);
      if (a_pix_en && pe_cyc.size() < 3) begin
        pe_cyc.push_back(c);
        pe_x.push_back(int'(a_x));
      end
      if (a_line_start) ls_cyc.push_back(c);
      if (b_frame_start) fs_cyc.push_back(c);
      if (!a_hsync && a_hs_prev && hs_start < 0) begin hs_start = c; hs_x = int'(a_x); end
      if (a_hsync && !a_hs_prev && hs_start >= 0 && hs_len < 0) hs_len = c - hs_start;
      if (b_vsync && !b_vs_prev && vs_start < 0) begin vs_start = c; vs_y = int'(b_y); end
      if (!b_vsync && b_vs_prev && vs_start >= 0 && vs_len < 0) vs_len = c - vs_start;
      a_hs_prev = a_hsync;
      b_vs_prev = b_vsync;
    end

    chk("pix_en_count", pe_cyc.size(), 3);
    if (pe_cyc.size() == 3) begin
      chk("pix_en_cyc0", pe_cyc[0], 4);
      chk("pix_en_cyc1", pe_cyc[1], 8);
      chk("pix_en_cyc2", pe_cyc[2], 12);
      chk("pix_en_x0", pe_x[0], 0);
      chk("pix_en_x1", pe_x[1], 1);
      chk("pix_en_x2", pe_x[2], 2);
    end
    chk("hsync_start_x", hs_x, 656);
    chk("hsync_low_len", hs_len, 384);
    chk("line_start_count", ls_cyc.size(), 2);
    if (ls_cyc.size() >= 2) chk("line_start_period", ls_cyc[1] - ls_cyc[0], 3200);
    chk("vsync_b_start_y", vs_y, 7);
    chk("vsync_b_len", vs_len, 3 * 17 * 2);
    chk("frame_start_b_ge2", fs_cyc.size() >= 2, 1);
    if (fs_cyc.size() >= 2) begin
      chk("frame_start_b_first", fs_cyc[0], 3 * 17 * 11 + 1);
      chk("frame_start_b_period", fs_cyc[1] - fs_cyc[0], 3 * 17 * 11);
    end

    // Randomised reset pulses at arbitrary points, including mid-frame.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(200, 1500)) @(negedge clk100);
      rst_n = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk100);
      rst_n = 1'b1;
    end

    // Directed mid-frame reset on instance B, then time the next frame_start.
    begin
      int t;
      t = 0;
      while (!(b_y == 10'd3 && b_x == 10'd5) && t < 2000) begin
        @(negedge clk100);
        t++;
      end
      chk("midframe_reached", t < 2000, 1);
      rst_n = 1'b0;
      @(negedge clk100);
      chk("midframe_rst_x", b_x, 0);
      chk("midframe_rst_y", b_y, 0);
      chk("midframe_rst_strobe", {b_line_start, b_frame_start}, 0);
      rst_n = 1'b1;
      t = 1;
      while (!b_frame_start && t < 2000) begin
        @(negedge clk100);
        t++;
      end
      chk("midframe_next_fs", t, 3 * 17 * 11 + 1);
    end

    repeat (2500) @(negedge clk100);
    repeat (2) @(negedge clk100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
